// File: rtl/mc_port_arbiter.sv
`default_nettype none
// ============================================================================
// mc_port_arbiter : round-robin share of one MC port among NUM_REQ requesters
// Revision: 1.0
// ============================================================================
module mc_port_arbiter #(
    parameter int NUM_REQ         = 4,
    parameter int ID_WID          = 2,
    parameter int TAG_WID         = 8,
    parameter int MC_RTNCTL_WIDTH = 32,
    parameter int MAX_OUT         = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_vld,
    input  logic [3*NUM_REQ-1:0]          req_cmd,
    input  logic [4*NUM_REQ-1:0]          req_scmd,
    input  logic [48*NUM_REQ-1:0]         req_vadr,
    input  logic [2*NUM_REQ-1:0]          req_size,
    input  logic [64*NUM_REQ-1:0]         req_data,
    input  logic [TAG_WID*NUM_REQ-1:0]    req_tag,
    output logic [NUM_REQ-1:0]            req_grant,
    output logic [NUM_REQ-1:0]            rsp_vld,
    output logic [2:0]                    rsp_cmd,
    output logic [63:0]                   rsp_data,
    output logic [TAG_WID-1:0]            rsp_tag,
    output logic                          mc_rq_vld,
    output logic [2:0]                    mc_rq_cmd,
    output logic [3:0]                    mc_rq_scmd,
    output logic [47:0]                   mc_rq_vadr,
    output logic [1:0]                    mc_rq_size,
    output logic [MC_RTNCTL_WIDTH-1:0]    mc_rq_rtnctl,
    output logic [63:0]                   mc_rq_data,
    output logic                          mc_rq_flush,
    input  logic                          mc_rq_stall,
    input  logic                          mc_rs_vld,
    input  logic [2:0]                    mc_rs_cmd,
    input  logic [3:0]                    mc_rs_scmd,
    input  logic [MC_RTNCTL_WIDTH-1:0]    mc_rs_rtnctl,
    input  logic [63:0]                   mc_rs_data,
    output logic                          mc_rs_stall,
    output logic                          busy
);

    localparam int                 C_CNT_WID = 8;
    localparam logic [C_CNT_WID-1:0] C_MAX_OUT = C_CNT_WID'(MAX_OUT);

    logic [ID_WID-1:0]    r_ptr;
    logic [C_CNT_WID-1:0] r_cnt [NUM_REQ];
    logic [NUM_REQ-1:0]   w_elig;
    logic [NUM_REQ-1:0]   w_inc;
    logic [NUM_REQ-1:0]   w_dec;
    logic                 w_can_grant;
    logic                 w_gnt_any;
    logic [ID_WID-1:0]    w_gnt_idx;
    logic [ID_WID-1:0]    w_cand;
    logic [ID_WID-1:0]    w_rs_id;
    logic                 w_cnt_nz;
    logic [2:0]           w_sel_cmd;
    logic [3:0]           w_sel_scmd;
    logic [47:0]          w_sel_vadr;
    logic [1:0]           w_sel_size;
    logic [63:0]          w_sel_data;
    logic [TAG_WID-1:0]   w_sel_tag;
    logic                 w_unused;

    // A full register may still accept a grant when it is draining this cycle.
    assign w_can_grant = !reset && (!mc_rq_vld || !mc_rq_stall);
    assign w_rs_id     = mc_rs_rtnctl[ID_WID+TAG_WID-1:TAG_WID];
    assign w_unused    = ^{mc_rs_scmd, mc_rs_rtnctl};

    always_comb begin
        w_elig   = '0;
        w_cnt_nz = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_elig[i] = req_vld[i] && (r_cnt[i] < C_MAX_OUT);
            w_cnt_nz  = w_cnt_nz | (r_cnt[i] != '0);
        end
    end

    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_cand    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_WID'((int'(r_ptr) + k) % NUM_REQ);
            if (w_can_grant && !w_gnt_any && w_elig[w_cand]) begin
                w_gnt_any = 1'b1;
                w_gnt_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_sel_cmd  = '0;
        w_sel_scmd = '0;
        w_sel_vadr = '0;
        w_sel_size = '0;
        w_sel_data = '0;
        w_sel_tag  = '0;
        w_inc      = '0;
        w_dec      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_inc[i] = w_gnt_any && (w_gnt_idx == ID_WID'(i));
            // Ids at or above NUM_REQ match no requester and are dropped here.
            w_dec[i] = mc_rs_vld && (w_rs_id == ID_WID'(i));
            if (w_gnt_idx == ID_WID'(i)) begin
                w_sel_cmd  = req_cmd[i*3 +: 3];
                w_sel_scmd = req_scmd[i*4 +: 4];
                w_sel_vadr = req_vadr[i*48 +: 48];
                w_sel_size = req_size[i*2 +: 2];
                w_sel_data = req_data[i*64 +: 64];
                w_sel_tag  = req_tag[i*TAG_WID +: TAG_WID];
            end
        end
    end

    assign req_grant   = w_inc;
    assign mc_rq_flush = 1'b0;
    assign mc_rs_stall = 1'b0;
    assign busy        = mc_rq_vld || w_cnt_nz;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr        <= '0;
            mc_rq_vld    <= 1'b0;
            mc_rq_cmd    <= '0;
            mc_rq_scmd   <= '0;
            mc_rq_vadr   <= '0;
            mc_rq_size   <= '0;
            mc_rq_rtnctl <= '0;
            mc_rq_data   <= '0;
        end else if (w_gnt_any) begin
            r_ptr        <= (w_gnt_idx == ID_WID'(NUM_REQ-1)) ? '0 : w_gnt_idx + 1'b1;
            mc_rq_vld    <= 1'b1;
            mc_rq_cmd    <= w_sel_cmd;
            mc_rq_scmd   <= w_sel_scmd;
            mc_rq_vadr   <= w_sel_vadr;
            mc_rq_size   <= w_sel_size;
            mc_rq_rtnctl <= MC_RTNCTL_WIDTH'({w_gnt_idx, w_sel_tag});
            mc_rq_data   <= w_sel_data;
        end else if (mc_rq_vld && !mc_rq_stall) begin
            mc_rq_vld    <= 1'b0;
        end
    end

    // Simultaneous increment and decrement cancel; a decrement at zero is ignored.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (reset) begin
                r_cnt[i] <= '0;
            end else if (w_inc[i] && !(w_dec[i] && r_cnt[i] != '0)) begin
                r_cnt[i] <= r_cnt[i] + 1'b1;
            end else if (!w_inc[i] && w_dec[i] && r_cnt[i] != '0) begin
                r_cnt[i] <= r_cnt[i] - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_vld  <= '0;
            rsp_cmd  <= '0;
            rsp_data <= '0;
            rsp_tag  <= '0;
        end else begin
            rsp_vld <= w_dec;
            if (|w_dec) begin
                rsp_cmd  <= mc_rs_cmd;
                rsp_data <= mc_rs_data;
                rsp_tag  <= mc_rs_rtnctl[TAG_WID-1:0];
            end
        end
    end

endmodule
`default_nettype wire
